// File: rtl/spi_dac_rx_if.sv
// Signal bundle between an SPI DAC-side master and the spi_dac_rx receiver.
// The master modport drives the SPI pins; the slave modport drives the latched DAC state.
interface spi_dac_rx_if;
    logic       dac_sck;
    logic       dac_cs;
    logic       dac_sdi;
    logic       dac_ld;
    logic [9:0] dac_data;
    logic       dac_update;
    logic       gain_x1;
    logic       shdn_n;
    logic       frame_valid;
    logic       frame_err;
    logic [7:0] frame_count;

    modport master (
        output dac_sck, dac_cs, dac_sdi, dac_ld,
        input  dac_data, dac_update, gain_x1, shdn_n,
               frame_valid, frame_err, frame_count
    );

    modport slave (
        input  dac_sck, dac_cs, dac_sdi, dac_ld,
        output dac_data, dac_update, gain_x1, shdn_n,
               frame_valid, frame_err, frame_count
    );
endinterface

// File: rtl/spi_dac_rx.sv
// Receives 16-bit DAC command words over a slow SPI link, validates each frame and
// transfers the pending word to the DAC outputs on a falling edge of the load strobe.
module spi_dac_rx #(
    parameter int SYNC_STAGES = 2  // legal range 2..3
) (
    input  logic         sysclk,
    input  logic         rst_n,
    spi_dac_rx_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_FULL,
        ST_OVER
    } state_t;

    state_t r_state;
    state_t w_next_state;

    logic [SYNC_STAGES-1:0] r_sck_sync;
    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic [SYNC_STAGES-1:0] r_sdi_sync;
    logic [SYNC_STAGES-1:0] r_ld_sync;

    logic r_sck_prev, r_cs_prev, r_ld_prev;
    logic r_sck_rise, r_cs_rise, r_cs_fall, r_ld_fall;
    logic r_sdi_q;

    logic [4:0]  r_bit_cnt;
    logic [15:0] r_shift;
    logic [9:0]  r_pend_data;
    logic        r_pend_ga;
    logic        r_pend_shdn;
    logic        r_pending;
    logic        r_ld_defer;

    logic [9:0]  r_dac_data;
    logic        r_dac_update;
    logic        r_gain_x1;
    logic        r_shdn_n;
    logic        r_frame_valid;
    logic        r_frame_err;
    logic [7:0]  r_frame_count;

    logic w_sck_s, w_cs_s, w_sdi_s, w_ld_s;
    logic w_frame_end, w_accept, w_reject, w_load;

    assign w_sck_s = r_sck_sync[SYNC_STAGES-1];
    assign w_cs_s  = r_cs_sync[SYNC_STAGES-1];
    assign w_sdi_s = r_sdi_sync[SYNC_STAGES-1];
    assign w_ld_s  = r_ld_sync[SYNC_STAGES-1];

    // Edge strobes are registered, so every event reaches the FSM one cycle after
    // it appears at the end of the synchroniser; sdi is delayed alongside sck.
    always_ff @(posedge sysclk) begin
        if (!rst_n) begin
            r_sck_sync <= '0;
            r_cs_sync  <= '0;
            r_sdi_sync <= '0;
            r_ld_sync  <= '0;
            r_sck_prev <= 1'b0;
            r_cs_prev  <= 1'b0;
            r_ld_prev  <= 1'b0;
            r_sck_rise <= 1'b0;
            r_cs_rise  <= 1'b0;
            r_cs_fall  <= 1'b0;
            r_ld_fall  <= 1'b0;
            r_sdi_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every stage take the previous value,
            // which is what turns these lines into a shift chain rather than a wire.
            r_sck_sync <= {r_sck_sync[SYNC_STAGES-2:0], bus.dac_sck};
            r_cs_sync  <= {r_cs_sync[SYNC_STAGES-2:0],  bus.dac_cs};
            r_sdi_sync <= {r_sdi_sync[SYNC_STAGES-2:0], bus.dac_sdi};
            r_ld_sync  <= {r_ld_sync[SYNC_STAGES-2:0],  bus.dac_ld};
            r_sck_prev <= w_sck_s;
            r_cs_prev  <= w_cs_s;
            r_ld_prev  <= w_ld_s;
            r_sck_rise <= w_sck_s & ~r_sck_prev;
            r_cs_rise  <= w_cs_s & ~r_cs_prev;
            r_cs_fall  <= ~w_cs_s & r_cs_prev;
            r_ld_fall  <= ~w_ld_s & r_ld_prev;
            r_sdi_q    <= w_sdi_s;
        end
    end

    always_ff @(posedge sysclk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        // NOTE: default first so every path assigns the next state and no latch is inferred.
        w_next_state = r_state;
        if (r_cs_rise) begin
            w_next_state = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:  if (r_cs_fall) w_next_state = ST_SHIFT;
                ST_SHIFT: if (r_sck_rise && r_bit_cnt == 5'd15) w_next_state = ST_FULL;
                ST_FULL:  if (r_sck_rise) w_next_state = ST_OVER;
                ST_OVER:  w_next_state = ST_OVER;
                default:  w_next_state = ST_IDLE;
            endcase
        end
    end

    // Only a full 16-bit word for channel A is accepted; any other terminated frame is an error.
    assign w_frame_end = r_cs_rise && (r_state != ST_IDLE);
    assign w_accept    = r_cs_rise && (r_state == ST_FULL) && !r_shift[15];
    assign w_reject    = w_frame_end && !w_accept;
    assign w_load      = r_pending && (r_state == ST_IDLE) && (r_ld_fall || r_ld_defer);

    always_ff @(posedge sysclk) begin
        if (!rst_n) begin
            // NOTE: the shift and pending registers are plain flops, not a memory, so
            // clearing them in reset is cheap and guarantees no stale word survives.
            r_bit_cnt     <= '0;
            r_shift       <= '0;
            r_pend_data   <= '0;
            r_pend_ga     <= 1'b0;
            r_pend_shdn   <= 1'b0;
            r_pending     <= 1'b0;
            r_ld_defer    <= 1'b0;
            r_dac_data    <= '0;
            r_dac_update  <= 1'b0;
            r_gain_x1     <= 1'b1;
            r_shdn_n      <= 1'b0;
            r_frame_valid <= 1'b0;
            r_frame_err   <= 1'b0;
            r_frame_count <= '0;
        end else begin
            r_frame_valid <= w_accept;
            r_frame_err   <= w_reject;
            r_dac_update  <= w_load;
            // A load strobe coinciding with the end of a frame is retried next cycle.
            r_ld_defer    <= r_ld_fall && w_frame_end;

            if (!r_cs_rise) begin
                if (r_state == ST_IDLE && r_cs_fall) begin
                    r_bit_cnt <= '0;
                end else if (r_state == ST_SHIFT && r_sck_rise) begin
                    r_shift   <= {r_shift[14:0], r_sdi_q};
                    r_bit_cnt <= r_bit_cnt + 5'd1;
                end
            end

            if (w_accept) begin
                r_pend_data   <= r_shift[11:2];
                r_pend_ga     <= r_shift[13];
                r_pend_shdn   <= r_shift[12];
                r_pending     <= 1'b1;
                r_frame_count <= r_frame_count + 8'd1;
            end else if (w_load) begin
                r_dac_data <= r_pend_data;
                r_gain_x1  <= r_pend_ga;
                r_shdn_n   <= r_pend_shdn;
                r_pending  <= 1'b0;
            end
        end
    end

    assign bus.dac_data    = r_dac_data;
    assign bus.dac_update  = r_dac_update;
    assign bus.gain_x1     = r_gain_x1;
    assign bus.shdn_n      = r_shdn_n;
    assign bus.frame_valid = r_frame_valid;
    assign bus.frame_err   = r_frame_err;
    assign bus.frame_count = r_frame_count;

endmodule

// File: tb/tb_spi_dac_rx.sv
// Scoreboard bench for spi_dac_rx: the SPI driver pushes expected frame and load
// outcomes, and a monitor pops and compares them whenever the DUT pulses.
module tb_spi_dac_rx;

    typedef struct {
        logic       ok;
        logic [7:0] cnt;
    } frame_exp_t;

    typedef struct {
        logic [9:0] data;
        logic       ga;
        logic       shdn;
    } upd_exp_t;

    logic sysclk = 1'b0;
    logic rst_n  = 1'b0;

    spi_dac_rx_if bus ();

    spi_dac_rx #(.SYNC_STAGES(2)) dut (
        .sysclk (sysclk),
        .rst_n  (rst_n),
        .bus    (bus.slave)
    );

    always #10 sysclk = ~sysclk;

    int n_checks = 0;
    int n_errors = 0;

    frame_exp_t q_frame[$];
    upd_exp_t   q_upd[$];

    logic [15:0] m_pend_word = 16'h0;
    logic        m_pending   = 1'b0;
    logic [7:0]  m_count     = 8'h0;
    logic [9:0]  m_data      = 10'h0;
    logic        m_ga        = 1'b1;
    logic        m_shdn      = 1'b0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    always @(posedge sysclk) begin
        #1;
        if (bus.frame_valid || bus.frame_err) begin
            if (q_frame.size() == 0) begin
                check("unexpected_frame_pulse", 32'({bus.frame_valid, bus.frame_err}), 32'h0);
            end else begin
                frame_exp_t e;
                e = q_frame.pop_front();
                check("frame_kind", 32'({bus.frame_valid, bus.frame_err}), e.ok ? 32'h2 : 32'h1);
                check("frame_count", 32'(bus.frame_count), 32'(e.cnt));
            end
        end
        if (bus.dac_update) begin
            if (q_upd.size() == 0) begin
                check("unexpected_update", 32'(bus.dac_update), 32'h0);
            end else begin
                upd_exp_t u;
                u = q_upd.pop_front();
                check("update_word", 32'({bus.dac_data, bus.gain_x1, bus.shdn_n}),
                      32'({u.data, u.ga, u.shdn}));
            end
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge sysclk);
    endtask

    task automatic model_load();
        upd_exp_t u;
        if (m_pending) begin
            m_data    = m_pend_word[11:2];
            m_ga      = m_pend_word[13];
            m_shdn    = m_pend_word[12];
            m_pending = 1'b0;
            u.data = m_data;
            u.ga   = m_ga;
            u.shdn = m_shdn;
            q_upd.push_back(u);
        end
    endtask

    task automatic send_bits(input logic [31:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            bus.dac_sdi = bits[i];
            wait_cyc(4);
            bus.dac_sck = 1'b1;
            wait_cyc(4);
            bus.dac_sck = 1'b0;
        end
    endtask

    // Sends n bits (MSB first) in one cs frame; optionally drops ld together with cs rising.
    task automatic send_frame(input logic [31:0] bits, input int n, input logic with_ld);
        frame_exp_t e;
        e.ok = (n == 16) && !bits[15];
        if (e.ok) begin
            m_pend_word = bits[15:0];
            m_pending   = 1'b1;
            m_count     = m_count + 8'd1;
        end
        e.cnt = m_count;
        bus.dac_cs = 1'b0;
        wait_cyc(4);
        send_bits(bits, n);
        wait_cyc(4);
        q_frame.push_back(e);
        if (with_ld) model_load();
        bus.dac_cs = 1'b1;
        if (with_ld) bus.dac_ld = 1'b0;
        repeat (3) @(posedge sysclk);
        #1;
        check("latency_early", 32'(bus.frame_valid | bus.frame_err), 32'h0);
        @(posedge sysclk);
        #1;
        check("latency_pulse", 32'(bus.frame_valid | bus.frame_err), 32'h1);
        if (with_ld) begin
            check("coincident_no_early_update", 32'(bus.dac_update), 32'h0);
            @(posedge sysclk);
            #1;
            check("coincident_update", 32'(bus.dac_update), 32'h1);
        end
        @(negedge sysclk);
        wait_cyc(4);
        bus.dac_ld = 1'b1;
        wait_cyc(8);
    endtask

    task automatic pulse_ld();
        model_load();
        bus.dac_ld = 1'b0;
        wait_cyc(8);
        bus.dac_ld = 1'b1;
        wait_cyc(8);
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "_dac_data"}, 32'(bus.dac_data), 32'(m_data));
        check({tag, "_gain_x1"}, 32'(bus.gain_x1), 32'(m_ga));
        check({tag, "_shdn_n"}, 32'(bus.shdn_n), 32'(m_shdn));
        check({tag, "_frame_count"}, 32'(bus.frame_count), 32'(m_count));
    endtask

    task automatic check_reset_state(input string tag);
        check(tag, 32'({bus.dac_data, bus.dac_update, bus.gain_x1, bus.shdn_n,
                        bus.frame_valid, bus.frame_err, bus.frame_count}),
              32'({10'h000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00}));
    endtask

    initial begin
        bus.dac_sck = 1'b0;
        bus.dac_cs  = 1'b1;
        bus.dac_sdi = 1'b0;
        bus.dac_ld  = 1'b1;
        wait_cyc(5);
        check_reset_state("reset_values");
        rst_n = 1'b1;
        wait_cyc(8);
        check_reset_state("after_release");

        // Single good frame and load.
        send_frame(32'h3FFC, 16, 1'b0);
        pulse_ld();
        check_outputs("good_frame");

        // Short and long frames are rejected; a load with nothing pending does nothing.
        send_frame(32'h3FFC >> 1, 15, 1'b0);
        send_frame({15'h0, 16'h3FFC, 1'b1}, 17, 1'b0);
        pulse_ld();
        check_outputs("bad_length");

        // Channel B is rejected; then a channel A word with GA=0.
        send_frame(32'hB200, 16, 1'b0);
        pulse_ld();
        check_outputs("chan_b");
        send_frame(32'h1004, 16, 1'b0);
        pulse_ld();
        check_outputs("ga0_frame");

        // Second frame overwrites the unloaded first one.
        send_frame(32'h3004, 16, 1'b0);
        send_frame(32'h3008, 16, 1'b0);
        pulse_ld();
        pulse_ld();
        check_outputs("overwrite");

        // Accepted-frame counter wraps after 256 accepted frames.
        while (m_count != 8'h00) begin
            send_frame(32'($urandom_range(0, 32'h7FFF)), 16, 1'b0);
        end
        check("count_wrap", 32'(bus.frame_count), 32'h0);
        pulse_ld();
        check_outputs("random_word");

        // Reset mid-frame discards the partial word; the orphan cs rise is ignored.
        bus.dac_cs = 1'b0;
        wait_cyc(4);
        send_bits(32'hA5, 8);
        rst_n = 1'b0;
        m_pending = 1'b0;
        m_count   = 8'h00;
        m_data    = 10'h000;
        m_ga      = 1'b1;
        m_shdn    = 1'b0;
        wait_cyc(4);
        rst_n = 1'b1;
        wait_cyc(4);
        bus.dac_cs = 1'b1;
        wait_cyc(12);
        check_reset_state("reset_mid_frame");
        pulse_ld();
        check_reset_state("ld_after_reset");

        // cs rise coincident with ld fall: acceptance first, load one cycle later.
        send_frame(32'h2154, 16, 1'b1);
        check_outputs("coincident");

        wait_cyc(20);
        check("frame_queue_drained", 32'(q_frame.size()), 32'h0);
        check("update_queue_drained", 32'(q_upd.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/spi_dac_rx.md
SPI_DAC_RX -- requirements
Module: spi_dac_rx

Interface
REQ-001 Parameter SYNC_STAGES, default 2: number of flip-flop stages on each asynchronous SPI input; legal range 2..3.
REQ-002 sysclk  input  1  system clock, 50 MHz; the only clock in the block.
REQ-003 rst_n  input  1  reset, synchronous to sysclk, active-low.
REQ-004 dac_sck  input  1  SPI serial clock from the DAC-side master; idles low; frequency at most sysclk/8.
REQ-005 dac_cs  input  1  SPI chip select, active-low; frames one 16-bit word.
REQ-006 dac_sdi  input  1  SPI serial data, MSB first, sampled on dac_sck rising edge.
REQ-007 dac_ld  input  1  load strobe, active-low; its falling edge transfers the pending word to the output.
REQ-008 dac_data  output  10  currently latched DAC code.
REQ-009 dac_update  output  1  one-cycle pulse when dac_data is (re)loaded.
REQ-010 gain_x1  output  1  latched GA bit; 1 = gain x1.
REQ-011 shdn_n  output  1  latched SHDN bit; 0 = output shut down.
REQ-012 frame_valid  output  1  one-cycle pulse when a well-formed frame has been accepted into the pending register.
REQ-013 frame_err  output  1  one-cycle pulse when a frame is rejected.
REQ-014 frame_count  output  8  count of accepted frames; wraps from 255 to 0.

Function
REQ-015 Synchronisation: dac_sck, dac_cs, dac_sdi and dac_ld each SHALL pass through SYNC_STAGES flip-flops; all edge detection SHALL use the synchronised signals only.
REQ-016 State machine: IDLE, SHIFT, FULL, OVER.
- IDLE -> SHIFT on a synchronised dac_cs falling edge; bit counter cleared.
- SHIFT: on each synchronised dac_sck rising edge, shift dac_sdi into bit 0 of a 16-bit shift register and increment the counter; counter reaching 16 -> FULL.
- FULL: a further sck rising edge -> OVER.
- Any state -> IDLE on a synchronised dac_cs rising edge.
REQ-017 Word format, bits [15:0]: [15] channel select (0 = A), [14] BUF (ignored), [13] GA, [12] SHDN, [11:2] data, [1:0] don't care.
REQ-018 On a cs rising edge in FULL with bit15 = 0:
- load the word into the pending register and set pending;
- pulse frame_valid;
- increment frame_count.
REQ-019 On a cs rising edge in SHIFT (fewer than 16 bits), in OVER (more than 16 bits), or in FULL with bit15 = 1: pulse frame_err; pending register and pending flag unchanged.
REQ-020 A cs rising edge in IDLE (no preceding falling edge seen) SHALL be ignored, with no pulse.
REQ-021 Latency: frame_valid or frame_err SHALL be high in the sysclk cycle exactly SYNC_STAGES+1 cycles after the first sysclk edge that samples dac_cs high.
REQ-022 Load: on a synchronised dac_ld falling edge while pending = 1 and the FSM is IDLE, in the next cycle:
- dac_data <= pending[11:2], gain_x1 <= pending[13], shdn_n <= pending[12];
- dac_update pulses and pending clears.
REQ-023 A dac_ld falling edge while pending = 0 or while the FSM is not IDLE SHALL be ignored, with no update.
REQ-024 A new accepted frame SHALL overwrite an unloaded pending word, with no error.
REQ-025 If a cs rising edge and a dac_ld falling edge are detected in the same cycle, frame acceptance SHALL occur first; the load SHALL take the newly accepted word one cycle later.
REQ-026 When shdn_n = 0, dac_data SHALL still be updated as latched; shutdown is reported only through shdn_n.
REQ-027 All outputs SHALL be registered.

Reset
REQ-028 While rst_n = 0 at a sysclk edge, the block SHALL clear all of the following: FSM -> IDLE, counter, shift register, pending register and flag, synchroniser stages, dac_data = 0, dac_update = 0, gain_x1 = 1, shdn_n = 0, frame_valid = 0, frame_err = 0, frame_count = 0.
REQ-029 Reset asserted mid-frame SHALL discard the partial frame; after release, the first cs rising edge without a preceding cs falling edge SHALL produce no pulse.

Verification
REQ-030 Frame 0x3FFC (A, GA = 1, SHDN = 1, data 0x3FF), then ld low -> frame_valid once, frame_count = 1, dac_update once, dac_data = 0x3FF, gain_x1 = 1, shdn_n = 1.
REQ-031 Frame of 15 bits, then frame of 17 bits -> two frame_err pulses, frame_count = 0, dac_data unchanged; a following ld produces no dac_update.
REQ-032 Frame 0xB200 (channel B) -> frame_err, no pending; then frame 0x1004 plus ld -> dac_data = 0x001, gain_x1 = 0, shdn_n = 1.
REQ-033 Frames 0x3004 then 0x3008 without ld, then ld -> a single dac_update, dac_data = 0x002; 256 accepted frames -> frame_count wraps to 0.
REQ-034 rst_n low after 8 of 16 bits, release, then cs high -> no pulse, all outputs at reset values; cs rise coincident with ld fall on a good frame -> frame_valid, then dac_update on the next cycle.
